// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI memory controller.
package idli_pkg;
  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  localparam int CMD_CYC  = 2;
  localparam int ADDR_CYC = 6;
  localparam int DATA_CYC = 4;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, DONE
  } ctl_state_t;
endpackage

// File: rtl/idli_sqi_arb_m.sv
// Two-way round-robin arbiter: bit 0 = fetch, bit 1 = data.
module idli_sqi_arb_m (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_ptr
);
  logic ptr_q, ptr_d;

  // ptr_q names the port granted last; on a tie the other port wins.
  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = ptr_q ? 2'b01 : 2'b10;
    ptr_d = ptr_q;
    if (i_advance && |o_grant) ptr_d = o_grant[1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= 1'b1;
    else       ptr_q <= ptr_d;
  end

  assign o_ptr = ptr_q;
endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI serial memory controller serving a fetch port and a data port.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter int DUMMY_CYC = 2
) (
  input  logic        i_ctl_gck,
  input  logic        i_ctl_rst,
  input  logic        i_ctl_f_req,
  input  logic [15:0] i_ctl_f_addr,
  output logic        o_ctl_f_ack,
  output logic        o_ctl_f_done,
  input  logic        i_ctl_d_req,
  input  logic        i_ctl_d_wr,
  input  logic [15:0] i_ctl_d_addr,
  input  logic [15:0] i_ctl_d_wdata,
  output logic        o_ctl_d_ack,
  output logic        o_ctl_d_done,
  output logic [15:0] o_ctl_rdata,
  output logic        o_ctl_cs_n,
  output sqi_data_t   o_ctl_sio,
  output logic        o_ctl_oe,
  input  sqi_data_t   i_ctl_sio
);
  localparam int CNT_W = 8;

  ctl_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [47:0] tx_q, tx_d, tx_new, tx_src;
  logic        cs_n_q, cs_n_d, oe_q, oe_d;
  sqi_data_t   sio_q, sio_d;
  logic        f_done_q, f_done_d, d_done_q, d_done_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  req, grant;
  logic        accept, port_ptr, drive, new_wr;
  logic [15:0] new_addr;

  assign req    = {i_ctl_d_req, i_ctl_f_req} & {2{(state_q == IDLE) && !i_ctl_rst}};
  assign accept = |grant;

  // The arbiter pointer doubles as the latched port for the transaction in flight.
  idli_sqi_arb_m u_arb (
    .i_clk     (i_ctl_gck),
    .i_rst     (i_ctl_rst),
    .i_req     (req),
    .i_advance (accept),
    .o_grant   (grant),
    .o_ptr     (port_ptr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    wr_d     = wr_q;
    new_wr   = grant[1] & i_ctl_d_wr;
    new_addr = grant[1] ? i_ctl_d_addr : i_ctl_f_addr;
    tx_new   = {new_wr ? SQI_CMD_WRITE : SQI_CMD_READ, 7'b0, new_addr, 1'b0,
                grant[1] ? i_ctl_d_wdata : 16'h0};
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = CMD;
          wr_d    = new_wr;
        end
      end
      CMD: if (cnt_q == CNT_W'(CMD_CYC - 1)) begin
        state_d = ADDR;
        cnt_d   = '0;
      end
      ADDR: if (cnt_q == CNT_W'(ADDR_CYC - 1)) begin
        state_d = (!wr_q && DUMMY_CYC > 0) ? DUMMY : DATA;
        cnt_d   = '0;
      end
      DUMMY: if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (cnt_q == CNT_W'(DATA_CYC - 1)) begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered: derive them from the state being entered.
    tx_src   = (state_q == IDLE) ? tx_new : tx_q;
    drive    = (state_d inside {CMD, ADDR}) || (state_d == DATA && wr_d);
    tx_d     = drive ? {tx_src[43:0], 4'h0} : tx_src;
    sio_d    = drive ? tx_src[47:44] : 4'h0;
    oe_d     = drive;
    cs_n_d   = !(state_d inside {CMD, ADDR, DUMMY, DATA});
    f_done_d = (state_d == DONE) && !port_ptr;
    d_done_d = (state_d == DONE) && port_ptr;
    rdata_d  = (state_q == DATA && !wr_q) ? {rdata_q[11:0], i_ctl_sio} : rdata_q;
  end

  always_ff @(posedge i_ctl_gck) begin
    if (i_ctl_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      tx_q     <= '0;
      cs_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      sio_q    <= '0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      tx_q     <= tx_d;
      cs_n_q   <= cs_n_d;
      oe_q     <= oe_d;
      sio_q    <= sio_d;
      f_done_q <= f_done_d;
      d_done_q <= d_done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_ctl_f_ack  = grant[0];
  assign o_ctl_d_ack  = grant[1];
  assign o_ctl_f_done = f_done_q;
  assign o_ctl_d_done = d_done_q;
  assign o_ctl_rdata  = rdata_q;
  assign o_ctl_cs_n   = cs_n_q;
  assign o_ctl_sio    = sio_q;
  assign o_ctl_oe     = oe_q;
endmodule
